// File: rtl/adder_pkg.sv
// Shared constants and types for the adder result path.
package adder_pkg;

  localparam int C_DATA_WIDTH = 8;
  localparam int C_DEPTH      = 4;

  typedef logic [C_DATA_WIDTH:0] res_t;

  localparam logic [7:0] DROP_CNT_MAX = 8'd255;

endpackage

// File: rtl/adder_fifo_mem.sv
// Register array for the result FIFO: one synchronous write port, one asynchronous read port.
module adder_fifo_mem #(
  parameter int G_WIDTH = 9,
  parameter int G_DEPTH = 4,
  localparam int AW = $clog2(G_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [G_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [G_WIDTH-1:0] o_rd_data
);

  logic [G_WIDTH-1:0] mem_q [G_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/adder_result_fifo.sv
// Circular FIFO behind the registered adder; results arriving while full and not
// draining are dropped and recorded in a sticky flag plus a saturating counter.
module adder_result_fifo
  import adder_pkg::*;
#(
  parameter int G_DATA_WIDTH = C_DATA_WIDTH,
  parameter int G_DEPTH      = C_DEPTH,
  localparam int AW = $clog2(G_DEPTH),
  localparam int PW = AW + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [G_DATA_WIDTH:0] i_C,
  input  logic                  i_ready,
  input  logic                  i_ovf_clr,
  output logic                  o_valid,
  output logic [G_DATA_WIDTH:0] o_C,
  output logic [PW-1:0]         o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow,
  output logic [7:0]            o_drop_cnt
);

  if ((G_DEPTH < 2) || ((G_DEPTH & (G_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("adder_result_fifo: G_DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic                  empty, full;
  logic                  pop, push, drop;
  logic [G_DATA_WIDTH:0] rd_dat;

  // Status comes from registered pointers only, never from this cycle's handshake.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign pop  = !empty && i_ready;
  assign push = i_valid && (!full || pop);
  assign drop = i_valid && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // A drop in the same cycle as a clear restarts the count at one.
    if (drop) begin
      ovf_d = 1'b1;
      if (i_ovf_clr) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != DROP_CNT_MAX) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (i_ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  adder_fifo_mem #(
    .G_WIDTH (G_DATA_WIDTH + 1),
    .G_DEPTH (G_DEPTH)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (push),
    .i_wr_addr (wr_ptr_q[AW-1:0]),
    .i_wr_data (i_C),
    .i_rd_addr (rd_ptr_q[AW-1:0]),
    .o_rd_data (rd_dat)
  );

  // Memory is never reset, so the head is masked while nothing valid is stored.
  assign o_valid    = !empty;
  assign o_C        = empty ? '0 : rd_dat;
  assign o_count    = wr_ptr_q - rd_ptr_q;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_overflow = ovf_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_adder_result_fifo.sv
// Scoreboard bench for adder_result_fifo: directed scenarios plus random traffic.
module tb_adder_result_fifo;
  import adder_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  res_t       i_C;
  logic       i_ready;
  logic       i_ovf_clr;
  logic       o_valid;
  res_t       o_C;
  logic [2:0] o_count;
  logic       o_full;
  logic       o_empty;
  logic       o_overflow;
  logic [7:0] o_drop_cnt;

  adder_result_fifo #(.G_DATA_WIDTH(DW), .G_DEPTH(DEPTH)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_C        (i_C),
    .i_ready    (i_ready),
    .i_ovf_clr  (i_ovf_clr),
    .o_valid    (o_valid),
    .o_C        (o_C),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_overflow (o_overflow),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  res_t exp_q[$];
  int   m_cnt    = 0;
  int   m_ovf    = 0;
  int   m_drop   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, compare status against the model and score each handshake.
  always @(negedge i_clk) begin
    if (mon_en && !i_rst) begin
      chk("count", int'(o_count), m_cnt);
      chk("valid", int'(o_valid), int'(m_cnt != 0));
      chk("full", int'(o_full), int'(m_cnt == DEPTH));
      chk("empty", int'(o_empty), int'(m_cnt == 0));
      chk("overflow", int'(o_overflow), m_ovf);
      chk("drop_cnt", int'(o_drop_cnt), m_drop);
      if (m_cnt == 0) begin
        chk("c_masked", int'(o_C), 0);
      end else if (i_ready) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underrun", 1, 0);
        end else begin
          chk("head_data", int'(o_C), int'(exp_q.pop_front()));
        end
      end
    end
  end

  // One clock of stimulus; entered and left just after a rising edge.
  task automatic cycle(input bit v, input res_t d, input bit r, input bit c);
    bit pop, push, drop;
    int n_cnt, n_ovf, n_drop;
    i_valid   = v;
    i_C       = d;
    i_ready   = r;
    i_ovf_clr = c;
    pop   = (m_cnt > 0) && r;
    push  = v && ((m_cnt < DEPTH) || pop);
    drop  = v && !push;
    if (push) exp_q.push_back(d);
    n_cnt  = m_cnt + int'(push) - int'(pop);
    n_ovf  = m_ovf;
    n_drop = m_drop;
    if (drop) begin
      n_ovf  = 1;
      n_drop = c ? 1 : ((m_drop >= 255) ? 255 : m_drop + 1);
    end else if (c) begin
      n_ovf  = 0;
      n_drop = 0;
    end
    @(posedge i_clk);
    #1;
    m_cnt  = n_cnt;
    m_ovf  = n_ovf;
    m_drop = n_drop;
    i_valid   = 1'b0;
    i_ready   = 1'b0;
    i_ovf_clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, int'(o_valid), 0);
    chk({tag, "_C"}, int'(o_C), 0);
    chk({tag, "_count"}, int'(o_count), 0);
    chk({tag, "_full"}, int'(o_full), 0);
    chk({tag, "_empty"}, int'(o_empty), 1);
    chk({tag, "_overflow"}, int'(o_overflow), 0);
    chk({tag, "_drop_cnt"}, int'(o_drop_cnt), 0);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_C = '0; i_ready = 1'b0; i_ovf_clr = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs("in_reset");
    i_rst = 1'b0;
    mon_en = 1'b1;
    cycle(0, '0, 0, 0);
    check_reset_outputs("after_reset");

    // Single result, then a single pop.
    cycle(1, 9'h1FE, 0, 0);
    chk("single_valid", int'(o_valid), 1);
    chk("single_C", int'(o_C), 'h1FE);
    chk("single_count", int'(o_count), 1);
    cycle(0, '0, 1, 0);
    chk("single_empty", int'(o_empty), 1);
    chk("single_C0", int'(o_C), 0);

    // Fill and drain four times so both pointers wrap.
    for (int rep = 0; rep < 4; rep++) begin
      for (int k = 1; k <= 4; k++) cycle(1, res_t'(k), 0, 0);
      chk("fill_full", int'(o_full), 1);
      chk("fill_count", int'(o_count), 4);
      for (int k = 1; k <= 4; k++) cycle(0, '0, 1, 0);
      chk("drain_empty", int'(o_empty), 1);
    end

    // Simultaneous push and pop while full.
    for (int k = 1; k <= 4; k++) cycle(1, res_t'(k), 0, 0);
    cycle(1, 9'h0AA, 1, 0);
    chk("pp_count", int'(o_count), 4);
    chk("pp_head", int'(o_C), 2);
    chk("pp_no_ovf", int'(o_overflow), 0);
    for (int k = 0; k < 4; k++) cycle(0, '0, 1, 0);

    // Overflow, saturation, clear, and clear colliding with a drop.
    for (int k = 1; k <= 4; k++) cycle(1, res_t'(k), 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, res_t'(9'h100 + k), 0, 0);
    chk("ovf_flag", int'(o_overflow), 1);
    chk("ovf_cnt3", int'(o_drop_cnt), 3);
    chk("ovf_head", int'(o_C), 1);
    for (int k = 0; k < 300; k++) cycle(1, res_t'($urandom_range(0, 511)), 0, 0);
    chk("ovf_sat", int'(o_drop_cnt), 255);
    cycle(0, '0, 0, 1);
    chk("clr_flag", int'(o_overflow), 0);
    chk("clr_cnt", int'(o_drop_cnt), 0);
    cycle(1, 9'h005, 0, 1);
    chk("clr_drop_flag", int'(o_overflow), 1);
    chk("clr_drop_cnt", int'(o_drop_cnt), 1);
    cycle(0, '0, 0, 1);

    // Reset in the middle of a drain with three entries held.
    cycle(0, '0, 1, 0);
    chk("mid_count3", int'(o_count), 3);
    i_rst = 1'b1;
    i_valid = 1'b1;
    i_C = 9'h077;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    m_cnt = 0; m_ovf = 0; m_drop = 0;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    check_reset_outputs("mid_reset_hold");
    i_rst = 1'b0;
    cycle(1, 9'h055, 0, 0);
    chk("post_rst_C", int'(o_C), 'h055);
    chk("post_rst_count", int'(o_count), 1);
    cycle(0, '0, 1, 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) < 60), res_t'($urandom_range(0, 511)),
            ($urandom_range(0, 99) < 50), ($urandom_range(0, 63) == 0));
    end
    for (int n = 0; n < DEPTH + 1; n++) cycle(0, '0, 1, 0);
    chk("final_empty", int'(o_empty), 1);
    chk("final_scoreboard", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
